iexecute: RTL

- Execute stage of the 5-stage RV32 pipeline; consumes the ID/EX outputs of idecode and closes the loop to ifetch via PCSrcE/PCTargetE.
- Performs operand forwarding, ALU operation, branch/jump resolution and branch-target add.
- Holds the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/iexecute.sv | 118 +++++++++++
 1 files changed

// File: rtl/iexecute.sv
// Execute stage of the RV32 pipeline: operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register that feeds the memory stage.
module iexecute #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic            JumpE,
   input  logic            BranchE,
   input  logic            ALUSrcE,
   input  logic [1:0]      ResultSrcE,
   input  logic [2:0]      ALUControlE,
   input  logic [4:0]      RdE,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] RD1E,
   input  logic [XLEN-1:0] RD2E,
   input  logic [XLEN-1:0] ImmExtE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic [1:0]      ForwardAE,
   input  logic [1:0]      ForwardBE,
   input  logic [XLEN-1:0] ResultW,
   output logic            PCSrcE,
   output logic [XLEN-1:0] PCTargetE,
   output logic            RegWriteM,
   output logic            MemWriteM,
   output logic [1:0]      ResultSrcM,
   output logic [4:0]      RdM,
   output logic [XLEN-1:0] ALUResultM,
   output logic [XLEN-1:0] WriteDataM,
   output logic [XLEN-1:0] PCPlus4M
);

   logic            r_reg_write;
   logic            r_mem_write;
   logic [1:0]      r_result_src;
   logic [4:0]      r_rd;
   logic [XLEN-1:0] r_alu_result;
   logic [XLEN-1:0] r_write_data;
   logic [XLEN-1:0] r_pc_plus4;

   logic [XLEN-1:0] w_src_a;
   logic [XLEN-1:0] w_write_data;
   logic [XLEN-1:0] w_src_b;
   logic [XLEN-1:0] w_alu_result;
   logic            w_zero;

   // Forwarding from M uses the registered (previous instruction) result;
   // code 11 falls back to the register-file value.
   always_comb begin
      w_src_a = RD1E;
      case (ForwardAE)
         2'b01:   w_src_a = ResultW;
         2'b10:   w_src_a = r_alu_result;
         default: w_src_a = RD1E;
      endcase
   end

   always_comb begin
      w_write_data = RD2E;
      case (ForwardBE)
         2'b01:   w_write_data = ResultW;
         2'b10:   w_write_data = r_alu_result;
         default: w_write_data = RD2E;
      endcase
   end

   assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;

   always_comb begin
      w_alu_result = '0;
      case (ALUControlE)
         3'b000: w_alu_result = w_src_a + w_src_b;
         3'b001: w_alu_result = w_src_a - w_src_b;
         3'b010: w_alu_result = w_src_a & w_src_b;
         3'b011: w_alu_result = w_src_a | w_src_b;
         3'b100: w_alu_result = w_src_a ^ w_src_b;
         3'b101: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
         3'b110: w_alu_result = w_src_a << w_src_b[4:0];
         3'b111: w_alu_result = w_src_a >> w_src_b[4:0];
         default: w_alu_result = '0;
      endcase
   end

   assign w_zero    = (w_alu_result == '0);
   assign PCTargetE = PCE + ImmExtE;
   assign PCSrcE    = ~reset & ((BranchE & w_zero) | JumpE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_reg_write  <= 1'b0;
         r_mem_write  <= 1'b0;
         r_result_src <= 2'b00;
         r_rd         <= 5'd0;
         r_alu_result <= '0;
         r_write_data <= '0;
         r_pc_plus4   <= '0;
      end else begin
         r_reg_write  <= RegWriteE;
         r_mem_write  <= MemWriteE;
         r_result_src <= ResultSrcE;
         r_rd         <= RdE;
         r_alu_result <= w_alu_result;
         r_write_data <= w_write_data;
         r_pc_plus4   <= PCPlus4E;
      end
   end

   assign RegWriteM  = r_reg_write;
   assign MemWriteM  = r_mem_write;
   assign ResultSrcM = r_result_src;
   assign RdM        = r_rd;
   assign ALUResultM = r_alu_result;
   assign WriteDataM = r_write_data;
   assign PCPlus4M   = r_pc_plus4;

endmodule
